// File: rtl/retire_monitor.sv
// retire_monitor: counts retired instructions, hands out per-channel order
// numbers, and watches for branch-to-self halt, watchdog timeout and
// malformed (non-contiguous) commit vectors.
module retire_monitor #(
   parameter int NRET    = 1,
   parameter int ORDER_W = 64,
   parameter int WDOG_W  = 32
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NRET-1:0]           commit,
   input  logic [NRET*32-1:0]        pc_rdata,
   input  logic [NRET*32-1:0]        pc_wdata,
   input  logic [WDOG_W-1:0]         wdog_limit,
   output logic [NRET*ORDER_W-1:0]   order,
   output logic [ORDER_W-1:0]        retired,
   output logic                      halt,
   output logic [31:0]               halt_pc,
   output logic                      timeout,
   output logic                      proto_err
);

   typedef enum logic [1:0] {
      RUN       = 2'd0,
      HALTED    = 2'd1,
      TIMED_OUT = 2'd2
   } state_t;

   state_t              state, state_nxt;
   logic [WDOG_W-1:0]   idle_cnt;
   logic [WDOG_W:0]     idle_inc;
   logic [2:0]          acc_cnt;
   logic                halt_hit;
   logic [31:0]         halt_pc_nxt;
   logic                gap_seen;
   logic                seen_zero;
   logic                stop;
   logic                wdog_expire;

   // Order numbers are a pure function of the running count.
   for (genvar i = 0; i < NRET; i++) begin : g_order
      assign order[i*ORDER_W +: ORDER_W] = retired + ORDER_W'(i);
   end

   // Scan channels oldest-first: accept the contiguous prefix, stop after the
   // first branch-to-self, flag any set bit sitting above a clear one.
   always_comb begin
      // NOTE: every variable gets a default before the loop so no path can
      // leave one unassigned and infer a latch.
      acc_cnt     = '0;
      halt_hit    = 1'b0;
      halt_pc_nxt = '0;
      gap_seen    = 1'b0;
      seen_zero   = 1'b0;
      stop        = 1'b0;
      for (int i = 0; i < NRET; i++) begin
         if (!commit[i]) begin
            seen_zero = 1'b1;
         end else if (seen_zero) begin
            gap_seen = 1'b1;
         end else if (!stop && state == RUN) begin
            acc_cnt = acc_cnt + 3'd1;
            if (pc_wdata[32*i +: 32] == pc_rdata[32*i +: 32]) begin
               halt_hit    = 1'b1;
               halt_pc_nxt = pc_rdata[32*i +: 32];
               stop        = 1'b1;
            end
         end
      end
   end

   // Watchdog fires when this idle cycle would reach the live limit.
   assign idle_inc    = {1'b0, idle_cnt} + {{WDOG_W{1'b0}}, 1'b1};
   assign wdog_expire = (state == RUN) && (acc_cnt == 3'd0) &&
                        (wdog_limit != '0) && (idle_inc >= {1'b0, wdog_limit});

   // Next-state: halt beats timeout; terminal states leave only through reset.
   always_comb begin
      state_nxt = state;
      case (state)
         RUN: begin
            if (halt_hit)         state_nxt = HALTED;
            else if (wdog_expire) state_nxt = TIMED_OUT;
         end
         default: state_nxt = state;
      endcase
   end

   // State register.
   always_ff @(posedge clk) begin
      // NOTE: clocked state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      if (rst) state <= RUN;
      else     state <= state_nxt;
   end

   // Counters, captured halt PC and sticky protocol error; frozen outside RUN.
   always_ff @(posedge clk) begin
      if (rst) begin
         retired   <= '0;
         idle_cnt  <= '0;
         halt_pc   <= '0;
         proto_err <= 1'b0;
      end else if (state == RUN) begin
         retired <= retired + ORDER_W'(acc_cnt);
         if (acc_cnt != 3'd0)      idle_cnt <= '0;
         else if (idle_cnt != '1)  idle_cnt <= idle_inc[WDOG_W-1:0];
         if (halt_hit)             halt_pc   <= halt_pc_nxt;
         if (gap_seen)             proto_err <= 1'b1;
      end
   end

   assign halt    = (state == HALTED);
   assign timeout = (state == TIMED_OUT);

endmodule

// File: doc/retire_monitor.md
RETIRE_MONITOR -- requirements
Module: retire_monitor

Interface
REQ-001 SHALL have parameter NRET, default 1, number of retire channels per cycle (legal 1..4).
REQ-002 SHALL have parameter ORDER_W, default 64, width of instruction order counter.
REQ-003 SHALL have parameter WDOG_W, default 32, width of watchdog counter and limit.
REQ-004 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port commit  input  NRET  per-channel retire valid; bit 0 is oldest.
REQ-007 SHALL have port pc_rdata  input  NRET*32  PC of retiring instruction per channel (channel i at bits 32i+31:32i).
REQ-008 SHALL have port pc_wdata  input  NRET*32  next PC of retiring instruction per channel.
REQ-009 SHALL have port wdog_limit  input  WDOG_W  consecutive no-commit cycles before timeout; 0 disables watchdog.
REQ-010 SHALL have port order  output  NRET*ORDER_W  order number assigned to each channel this cycle.
REQ-011 SHALL have port retired  output  ORDER_W  total instructions accepted since reset.
REQ-012 SHALL have port halt  output  1  registered; program reached branch-to-self.
REQ-013 SHALL have port halt_pc  output  32  PC of the halting instruction.
REQ-014 SHALL have port timeout  output  1  registered; watchdog expired.
REQ-015 SHALL have port proto_err  output  1  sticky; non-contiguous commit vector seen.

Function
REQ-016 SHALL implement FSM states RUN, HALTED, TIMED_OUT; HALTED and TIMED_OUT exit only by reset.
REQ-017 SHALL, in RUN, treat commit as accepted only for channels 0..k-1 where k = number of contiguous set bits from bit 0, truncated at the halting channel (inclusive).
REQ-018 SHALL drive order[i] combinationally = retired + i for every channel i (valid only where accepted).
REQ-019 SHALL add the accepted count (0..NRET) to retired at the clock edge, wrapping modulo 2^ORDER_W.
REQ-020 SHALL detect halt on accepted channel i when pc_wdata[i] == pc_rdata[i]; lowest such i wins, channels above i are discarded.
REQ-021 SHALL, on halt detection, transition RUN->HALTED, assert halt and load halt_pc with pc_rdata[i] on the next edge (1-cycle latency).
REQ-022 SHALL keep an idle counter: cleared on any cycle with accepted count > 0, else incremented, saturating at all-ones.
REQ-023 SHALL transition RUN->TIMED_OUT and assert timeout on the edge where wdog_limit != 0 and idle counter + 1 >= wdog_limit with no accepted commit.
REQ-024 SHALL give halt priority over timeout when both conditions occur in the same cycle.
REQ-025 SHALL, in HALTED or TIMED_OUT, accept no commits: retired, idle counter, halt_pc frozen.
REQ-026 SHALL set proto_err when commit has a 1 above a 0 (e.g. 4'b0101) in RUN; bits above the gap are not accepted.
REQ-027 SHALL treat wdog_limit changes as live (compared every cycle, not latched).
REQ-028 SHALL be fully synthesizable with no simulation-only constructs.

Reset
REQ-029 SHALL on rst: state=RUN, retired=0, idle=0, halt=0, halt_pc=0, timeout=0, proto_err=0.
REQ-030 SHALL let rst override all events in the same cycle, including a halt or timeout condition mid-operation.

Verification
REQ-031 NRET=2: commit=2'b11 for 3 cycles, PCs non-self -> order pairs (0,1),(2,3),(4,5); retired=6.
REQ-032 NRET=2: commit=2'b11, ch0 pc_rdata=pc_wdata=0x60000100 -> next cycle halt=1, halt_pc=0x60000100, retired +1 only; later commits ignored.
REQ-033 wdog_limit=5, commit=0 for 5 cycles -> timeout=1 after 5th edge; wdog_limit=0, 1000 idle cycles -> timeout stays 0.
REQ-034 NRET=4: commit=4'b1011 -> proto_err=1, retired +2; proto_err stays 1 until rst.
REQ-035 ORDER_W=8, retired preloaded to 255 via 255 single commits, then commit=1 -> order=255, retired wraps to 0.
REQ-036 Halt condition and rst asserted same cycle -> halt=0, retired=0, state RUN next cycle.
